tt_um_toivoh_test: RTL and testbench

TT_UM_TOIVOH_TEST -- requirements
Module: tt_um_toivoh_test

---
 rtl/tt_um_toivoh_test_pkg.sv | 26 ++
 rtl/tt_um_toivoh_test_serial_rx.sv | 67 ++++++
 rtl/tt_um_toivoh_test.sv | 127 ++++++++++++
 tb/tb_tt_um_toivoh_test.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_toivoh_test_pkg.sv
// Shared constants for the serial-RAM address walker: word width,
// frame-length derivation, ui_in bit positions and output-select codes.
package tt_um_toivoh_test_pkg;

    // Width of one RAM word and of the address register.
    localparam int W = 16;

    // ui_in control bit positions.
    localparam int UI_JUMP    = 0;
    localparam int UI_SEL_LSB = 1;
    localparam int UI_HOLD    = 3;

    // Byte routed to uio_out, selected by ui_in[2:1].
    typedef enum logic [1:0] {
        SEL_WD_LO  = 2'b00,
        SEL_WD_HI  = 2'b01,
        SEL_SUM_LO = 2'b10,
        SEL_SUM_HI = 2'b11
    } out_sel_e;

    // Number of cycles in one RAM frame.
    function automatic int cycles_of(input int log2_cycles);
        return 1 << log2_cycles;
    endfunction

endpackage

// File: rtl/tt_um_toivoh_test_serial_rx.sv
// Assembles the nibbles returned by the serial RAM into words.
// The slot written each cycle is the frame phase shifted by the round-trip
// latency, so the lane index lines up with the nibble the RAM is returning.
// o_done fires on the cycle whose edge captures the final nibble of a word;
// o_word then already holds the complete word (last nibble taken live).
module tt_um_toivoh_test_serial_rx
    import tt_um_toivoh_test_pkg::*;
#(
    parameter int PINS        = 4,
    parameter int LOG2_CYCLES = 2,
    parameter int EXTRA_DELAY = 3
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic [LOG2_CYCLES-1:0] i_phase,
    input  logic [PINS-1:0]        i_data,
    output logic                   o_done,
    output logic [W-1:0]           o_word
);

    localparam int CYCLES     = cycles_of(LOG2_CYCLES);
    // Cycles from sending address nibble k to sampling data nibble k.
    localparam int LAT        = CYCLES + 1 + EXTRA_DELAY;
    // Cycle (counted from reset) whose edge completes the first real word.
    localparam int FIRST_DONE = LAT + CYCLES - 1;
    localparam int SKEW       = (CYCLES - (LAT % CYCLES)) % CYCLES;
    localparam int FILL_W     = $clog2(FIRST_DONE + 1);

    logic [LOG2_CYCLES-1:0] w_idx;
    logic [FILL_W-1:0]      r_fill_reg;
    logic                   w_filled;

    assign w_idx    = i_phase + LOG2_CYCLES'(SKEW);
    assign w_filled = (r_fill_reg == FILL_W'(FIRST_DONE));
    assign o_done   = w_filled && (w_idx == LOG2_CYCLES'(CYCLES - 1));

    // Count cycles since reset until the first round trip has elapsed.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_fill_reg <= '0;
        end else if (!w_filled) begin
            r_fill_reg <= r_fill_reg + FILL_W'(1);
        end
    end

    // The top lane is never stored: it is consumed on the completing edge.
    assign o_word[PINS*(CYCLES-1) +: PINS] = i_data;

    genvar gi;
    generate
        for (gi = 0; gi < CYCLES - 1; gi++) begin : g_lane
            logic [PINS-1:0] r_lane_reg;

            // Capture the incoming nibble when this lane is the active slot.
            always_ff @(posedge clk) begin
                if (srst) begin
                    r_lane_reg <= '0;
                end else if (w_idx == LOG2_CYCLES'(gi)) begin
                    r_lane_reg <= i_data;
                end
            end

            assign o_word[PINS*gi +: PINS] = r_lane_reg;
        end
    endgenerate

endmodule

// File: rtl/tt_um_toivoh_test.sv
// Serial RAM address walker: sends a 16-bit address nibble-serially each
// frame, receives the addressed word a fixed latency later, accumulates a
// running sum and picks the next address (hold / jump-to-word / increment).
module tt_um_toivoh_test
    import tt_um_toivoh_test_pkg::*;
#(
    parameter int RAM_PINS        = 4,
    parameter int RAM_LOG2_CYCLES = 2,
    parameter int RAM_EXTRA_DELAY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CYCLES = cycles_of(RAM_LOG2_CYCLES);

    logic [RAM_LOG2_CYCLES-1:0] r_phase_reg;
    logic [W-1:0]               r_addr_reg;
    logic [W-1:0]               w_addr_next;
    logic [W-1:0]               r_wd_reg;
    logic [W-1:0]               r_sum_reg;
    logic                       r_valid_reg;
    logic                       r_strobe_reg;

    logic                       w_last_phase;
    logic                       w_done;
    logic [W-1:0]               w_word;
    logic                       w_have_word;
    logic [W-1:0]               w_jump_target;
    logic [RAM_PINS-1:0]        w_addr_nib;
    logic [7:0]                 w_uo;
    logic [7:0]                 w_uio;
    out_sel_e                   w_sel;
    logic                       w_unused;

    assign w_unused = &{1'b0, ena, uio_in, ui_in};

    tt_um_toivoh_test_serial_rx #(
        .PINS        (RAM_PINS),
        .LOG2_CYCLES (RAM_LOG2_CYCLES),
        .EXTRA_DELAY (RAM_EXTRA_DELAY)
    ) u_rx (
        .clk     (clk),
        .srst    (reset),
        .i_phase (r_phase_reg),
        .i_data  (ui_in[7 -: RAM_PINS]),
        .o_done  (w_done),
        .o_word  (w_word)
    );

    assign w_last_phase  = (r_phase_reg == RAM_LOG2_CYCLES'(CYCLES - 1));
    // A word completing on this very edge is usable for the jump.
    assign w_have_word   = r_valid_reg | w_done;
    assign w_jump_target = w_done ? w_word : r_wd_reg;

    // Next-address decision, taken only at the end of a frame.
    always_comb begin
        w_addr_next = r_addr_reg;
        if (w_last_phase) begin
            if (ui_in[UI_HOLD]) begin
                w_addr_next = r_addr_reg;
            end else if (ui_in[UI_JUMP] && w_have_word) begin
                w_addr_next = w_jump_target;
            end else begin
                w_addr_next = r_addr_reg + W'(1);
            end
        end
    end

    // Phase, address, received word, running sum and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase_reg  <= '0;
            r_addr_reg   <= '0;
            r_wd_reg     <= '0;
            r_sum_reg    <= '0;
            r_valid_reg  <= 1'b0;
            r_strobe_reg <= 1'b0;
        end else begin
            r_phase_reg  <= r_phase_reg + RAM_LOG2_CYCLES'(1);
            r_addr_reg   <= w_addr_next;
            r_strobe_reg <= w_done;
            if (w_done) begin
                r_wd_reg    <= w_word;
                r_sum_reg   <= r_sum_reg + w_word;
                r_valid_reg <= 1'b1;
            end
        end
    end

    assign w_addr_nib = r_addr_reg[RAM_PINS*r_phase_reg +: RAM_PINS];

    // Pack the address nibble and status bits onto uo_out.
    always_comb begin
        w_uo                 = 8'h00;
        w_uo[7 -: RAM_PINS]  = w_addr_nib;
        w_uo[3:2]            = r_phase_reg[1:0];
        w_uo[1]              = r_strobe_reg;
        w_uo[0]              = r_valid_reg;
    end

    assign w_sel = out_sel_e'(ui_in[UI_SEL_LSB +: 2]);

    // Route the selected byte of the word or sum to uio_out.
    always_comb begin
        w_uio = 8'h00;
        case (w_sel)
            SEL_WD_LO:  w_uio = r_wd_reg[7:0];
            SEL_WD_HI:  w_uio = r_wd_reg[15:8];
            SEL_SUM_LO: w_uio = r_sum_reg[7:0];
            SEL_SUM_HI: w_uio = r_sum_reg[15:8];
            default:    w_uio = 8'h00;
        endcase
    end

    // Outputs read as zero for the whole time reset is asserted.
    assign uo_out  = reset ? 8'h00 : w_uo;
    assign uio_out = reset ? 8'h00 : w_uio;
    assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_toivoh_test.sv
// Bench for tt_um_toivoh_test with a behavioural serial RAM model.
module tb_tt_um_toivoh_test;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ena = 1'b1;
    logic [7:0] ui_in;
    logic [7:0] uio_in = 8'h00;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    logic [3:0] ui_lo = 4'h0;

    // Serial RAM model state.
    logic [15:0] ram [0:4095];
    logic [1:0]  m_ph;
    logic [15:0] m_lat;
    logic [15:0] m_full;
    logic [15:0] m_sh;
    logic [3:0]  m_d0, m_d1, m_d2;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [15:0] acc;
    logic [15:0] exp_addr_q [$];
    logic [7:0]  exp_byte_q [$];

    assign ui_in = {m_d2, ui_lo};

    tt_um_toivoh_test dut (
        .clk     (clk),
        .reset   (reset),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // External RAM: latch address nibbles, read on phase 0, shift out LSB first.
    always @(posedge clk) begin
        if (reset) begin
            m_ph   <= 2'd0;
            m_lat  <= 16'h0;
            m_full <= 16'h0;
            m_sh   <= 16'h0;
            m_d0   <= 4'h0;
            m_d1   <= 4'h0;
            m_d2   <= 4'h0;
        end else begin
            m_ph <= m_ph + 2'd1;
            m_lat[4*m_ph +: 4] <= uo_out[7:4];
            if (m_ph == 2'd3) m_full <= {uo_out[7:4], m_lat[11:0]};
            if (m_ph == 2'd0) m_sh <= ram[m_full[11:0]];
            else              m_sh <= m_sh >> 4;
            m_d0 <= m_sh[3:0];
            m_d1 <= m_d0;
            m_d2 <= m_d1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // Per-cycle checks against the bench's own cycle count and scoreboards.
    task automatic check_cycle();
        chk("phase", 16'(uo_out[3:2]), 16'(cyc % 4));
        chk("strobe", 16'(uo_out[1]), 16'((cyc >= 12) && (cyc % 4 == 0)));
        chk("valid", 16'(uo_out[0]), 16'(cyc >= 12));
        acc[4*(cyc%4) +: 4] = uo_out[7:4];
        if ((cyc % 4 == 3) && (exp_addr_q.size() > 0)) begin
            $display("frame %0d addr=%h", cyc / 4, acc);
            chk("addr", acc, exp_addr_q.pop_front());
        end
        if (uo_out[1] && (exp_byte_q.size() > 0)) begin
            $display("cycle %0d word byte=%h", cyc, uio_out);
            chk("word_byte", 16'(uio_out), 16'(exp_byte_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    // One-edge reset; returns observing cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_uo", 16'(uo_out), 16'h0000);
        chk("rst_uio", 16'(uio_out), 16'h0000);
        chk("rst_oe", 16'(uio_oe), 16'h00FF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        acc = 16'h0;
        exp_addr_q.delete();
        exp_byte_q.delete();
        #1;
        check_cycle();
    endtask

    task automatic fill_seq();
        for (int i = 0; i < 4096; i++) ram[i] = 16'hA000 + 16'(i);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_addr_q"}, 16'(exp_addr_q.size()), 16'h0);
        chk({tag, "_byte_q"}, 16'(exp_byte_q.size()), 16'h0);
    endtask

    initial begin
        fill_seq();
        repeat (2) @(negedge clk);

        // Sequential walk, low word byte.
        ui_lo = 4'b0000;
        do_reset();
        for (int j = 0; j < 5; j++) exp_addr_q.push_back(16'(j));
        for (int j = 0; j < 3; j++) exp_byte_q.push_back(ram[j][7:0]);
        run_to(11);
        chk("seq_uio_c11", 16'(uio_out), 16'h0000);
        run_to(16);
        chk("seq_uio_c16", 16'(uio_out), 16'h0001);
        run_to(21);
        check_drained("seq");

        // Mid-frame reset at cycle 21.
        do_reset();
        chk("mrst_nib0", 16'(uo_out[7:4]), 16'h0);
        for (int j = 0; j < 4; j++) exp_addr_q.push_back(16'(j));
        exp_byte_q.push_back(8'h00);
        exp_byte_q.push_back(8'h01);
        run_to(11);
        chk("mrst_uio_c11", 16'(uio_out), 16'h0000);
        run_to(16);
        chk("mrst_uio_c16", 16'(uio_out), 16'h0001);
        check_drained("mrst");

        // High byte of the word.
        ui_lo = 4'b0010;
        do_reset();
        run_to(12);
        chk("hi_byte", 16'(uio_out), 16'h00A0);

        // Running sum low byte over three words.
        ram[0] = 16'h0001;
        ram[1] = 16'h0002;
        ram[2] = 16'h0003;
        ui_lo = 4'b0100;
        do_reset();
        run_to(12);
        chk("sum_c12", 16'(uio_out), 16'h0001);
        run_to(16);
        chk("sum_c16", 16'(uio_out), 16'h0003);
        run_to(20);
        chk("sum_c20", 16'(uio_out), 16'h0006);

        // Jump mode from reset.
        fill_seq();
        ram[0] = 16'h0100;
        ui_lo = 4'b0001;
        do_reset();
        exp_addr_q.push_back(16'h0000);
        exp_addr_q.push_back(16'h0001);
        exp_addr_q.push_back(16'h0002);
        exp_addr_q.push_back(16'h0100);
        exp_addr_q.push_back(16'hA001);
        exp_addr_q.push_back(16'hA002);
        exp_addr_q.push_back(16'hA100);
        exp_byte_q.push_back(8'h00);
        exp_byte_q.push_back(8'h01);
        exp_byte_q.push_back(8'h02);
        exp_byte_q.push_back(8'h00);
        run_to(27);
        check_drained("jump");

        // Hold: address stays 0, strobe still once per frame.
        fill_seq();
        ui_lo = 4'b1000;
        do_reset();
        for (int j = 0; j < 6; j++) exp_addr_q.push_back(16'h0000);
        for (int j = 0; j < 3; j++) exp_byte_q.push_back(8'h00);
        run_to(23);
        check_drained("hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
